// File: rtl/bus_pkg.sv
// Shared definitions for the system bus arbiter and its timeout timer.
package bus_pkg;

   // Arbiter ownership states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } arb_state_e;

   // Bank select values carried in adr[31:24].
   localparam logic [7:0] BANK_RAM   = 8'h00;
   localparam logic [7:0] BANK_LED   = 8'h01;
   localparam logic [7:0] BANK_VIDEO = 8'h02;
   localparam logic [7:0] BANK_UART  = 8'h03;

   // Read data handed back to a master whose transfer timed out.
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_timeout.sv
// Per-transfer watchdog: a down-counter loaded with TIMEOUT when a grant starts.
// It decrements once per waiting cycle and flags expiry at terminal count zero.
// With a load on the grant edge, expiry lands exactly TIMEOUT cycles after the
// first granted cycle.
module bus_timeout
   import bus_pkg::*;
#(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic clk,
   input  logic rst_ni,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);

   logic [7:0] cnt_q, cnt_d;

   // Load on grant, count down while the slave keeps the master waiting.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = TIMEOUT;
      end else if (en_i && (cnt_q != 8'd0)) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == 8'd0);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the shared stb/ack system bus, with a per-transfer
// timeout so an unmapped or hung bank cannot stall a master.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no owner; slave outputs held at 0, pending requests arbitrated
// GNT0  | master 0 owns the bus until slave ack, timeout or stb drop
// GNT1  | master 1 owns the bus until slave ack, timeout or stb drop
module bus_arbiter
   import bus_pkg::*;
#(
   parameter logic [7:0]  TIMEOUT    = 8'd255,
   parameter bit          FIXED_PRIO = 1'b0,
   parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_ni,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_adr_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_dat_i,
   output logic        m0_ack_o,
   output logic [31:0] m0_dat_o,
   output logic        m0_err_o,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_adr_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_dat_i,
   output logic        m1_ack_o,
   output logic [31:0] m1_dat_o,
   output logic        m1_err_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [31:0] s_adr_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_dat_o,
   input  logic        s_ack_i,
   input  logic [31:0] s_dat_i,
   output logic [1:0]  grant_o
);

   arb_state_e  state_q, state_d;
   logic        last_gnt_q, last_gnt_d;
   logic        owner;
   logic        own_stb, own_we;
   logic [3:0]  own_sel;
   logic [31:0] own_adr, own_dat;
   logic        tmo_load, tmo_en, tmo_expire;
   logic        tmo_fire, xfer_ack;

   // Request fields of whichever master currently owns the bus; zero when idle.
   always_comb begin
      owner   = (state_q == ST_GNT1);
      own_stb = 1'b0;
      own_we  = 1'b0;
      own_sel = 4'd0;
      own_adr = 32'd0;
      own_dat = 32'd0;
      if (state_q == ST_GNT0) begin
         own_stb = m0_stb_i;
         own_we  = m0_we_i;
         own_sel = m0_sel_i;
         own_adr = m0_adr_i;
         own_dat = m0_dat_i;
      end else if (state_q == ST_GNT1) begin
         own_stb = m1_stb_i;
         own_we  = m1_we_i;
         own_sel = m1_sel_i;
         own_adr = m1_adr_i;
         own_dat = m1_dat_i;
      end
   end

   // A slave ack in the expiry cycle takes precedence over the timeout.
   assign tmo_fire = own_stb && !s_ack_i && tmo_expire;
   assign xfer_ack = own_stb && (s_ack_i || tmo_expire);

   // Next state, fairness bookkeeping and timer control.
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      tmo_load   = 1'b0;
      tmo_en     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (m0_stb_i && m1_stb_i) begin
               state_d = (FIXED_PRIO || last_gnt_q) ? ST_GNT0 : ST_GNT1;
            end else if (m0_stb_i) begin
               state_d = ST_GNT0;
            end else if (m1_stb_i) begin
               state_d = ST_GNT1;
            end
            tmo_load = m0_stb_i || m1_stb_i;
         end
         ST_GNT0, ST_GNT1: begin
            if (!own_stb) begin
               // Master abandoned the request: release without touching fairness.
               state_d = ST_IDLE;
            end else if (xfer_ack) begin
               state_d    = ST_IDLE;
               last_gnt_d = owner;
            end else begin
               tmo_en = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and last-owner registers; master 0 wins the first tie after reset.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         last_gnt_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   bus_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .rst_ni   (rst_ni),
      .load_i   (tmo_load),
      .en_i     (tmo_en),
      .expire_o (tmo_expire)
   );

   // Slave-side mux and per-master response steering.
   always_comb begin
      s_stb_o  = own_stb && !tmo_fire;
      s_we_o   = own_we;
      s_adr_o  = own_adr;
      s_sel_o  = own_sel;
      s_dat_o  = own_dat;
      m0_ack_o = (state_q == ST_GNT0) && xfer_ack;
      m1_ack_o = (state_q == ST_GNT1) && xfer_ack;
      m0_err_o = (state_q == ST_GNT0) && tmo_fire;
      m1_err_o = (state_q == ST_GNT1) && tmo_fire;
      m0_dat_o = 32'd0;
      m1_dat_o = 32'd0;
      if (state_q == ST_GNT0) begin
         m0_dat_o = tmo_fire ? ERR_DATA : s_dat_i;
      end else if (state_q == ST_GNT1) begin
         m1_dat_o = tmo_fire ? ERR_DATA : s_dat_i;
      end
      grant_o = {state_q == ST_GNT1, state_q == ST_GNT0};
   end

endmodule
